// File: rtl/alu_seq_pkg.sv
// Shared definitions for the sequential 16-bit execute unit: opcodes, FSM states,
// iteration-engine modes and the flag bundle.
package alu_seq_pkg;

    localparam int ALU_W = 16;

    typedef logic [3:0] opcode_t;

    localparam opcode_t OP_ADD = 4'd0;
    localparam opcode_t OP_SUB = 4'd1;
    localparam opcode_t OP_AND = 4'd2;
    localparam opcode_t OP_OR  = 4'd3;
    localparam opcode_t OP_XOR = 4'd4;
    localparam opcode_t OP_NOT = 4'd5;
    localparam opcode_t OP_SHL = 4'd6;
    localparam opcode_t OP_SHR = 4'd7;
    localparam opcode_t OP_MUL = 4'd8;
    localparam opcode_t OP_DIV = 4'd9;

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXEC,
        S_ITER,
        S_DONE
    } state_t;

    typedef enum logic {
        MODE_MUL,
        MODE_DIV
    } mode_t;

    typedef struct packed {
        logic n;
        logic z;
        logic c;
        logic v;
    } flags_t;

    // Divide-by-zero is resolved on the single-cycle path, so only real MUL/DIV iterate.
    function automatic logic is_iterative(opcode_t op, logic b_zero);
        return (op == OP_MUL) || ((op == OP_DIV) && !b_zero);
    endfunction

endpackage

// File: rtl/alu_seq16_if.sv
// Request/response bundle between the register-file read buses and the execute unit.
interface alu_seq16_if
    import alu_seq_pkg::*;
#(
    parameter int W = ALU_W
) ();

    logic          start;
    opcode_t       op;
    logic [W-1:0]  a;
    logic [W-1:0]  b;

    logic [W-1:0]  result;
    logic [W-1:0]  result_hi;
    logic          flag_n;
    logic          flag_z;
    logic          flag_c;
    logic          flag_v;
    logic          err;
    logic          busy;
    logic          done;
    logic          wr_en;

    modport master (
        output start, op, a, b,
        input  result, result_hi, flag_n, flag_z, flag_c, flag_v, err, busy, done, wr_en
    );

    modport slave (
        input  start, op, a, b,
        output result, result_hi, flag_n, flag_z, flag_c, flag_v, err, busy, done, wr_en
    );

endinterface

// File: rtl/seq_muldiv16.sv
// Iteration engine: W-cycle unsigned shift-add multiply or restoring divide over a
// 2W accumulator; fin pulses for one cycle after the last iteration.
module seq_muldiv16
    import alu_seq_pkg::*;
#(
    parameter int W = ALU_W
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          go,
    input  mode_t         mode,
    input  logic [W-1:0]  a,
    input  logic [W-1:0]  b,
    output logic [W-1:0]  lo,
    output logic [W-1:0]  hi,
    output logic          fin
);

    localparam int CW = $clog2(W);

    logic [2*W-1:0] acc;
    logic [2*W-1:0] acc_nxt;
    logic [W-1:0]   opnd;
    logic [CW-1:0]  cnt;
    logic           run;
    mode_t          mode_q;

    logic [W:0]     mul_sum;
    logic [W:0]     div_rem;
    logic [W:0]     div_trial;

    // MUL: acc = {partial, multiplier}, opnd = multiplicand.
    // DIV: acc = {remainder, dividend/quotient}, opnd = divisor.
    assign mul_sum   = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, opnd} : '0);
    assign div_rem   = acc[2*W-1:W-1];
    assign div_trial = div_rem - {1'b0, opnd};

    // NOTE: every always_comb output gets a value on every path, otherwise a latch is inferred.
    always_comb begin
        acc_nxt = acc;
        if (mode_q == MODE_MUL) begin
            acc_nxt = {mul_sum, acc[W-1:1]};
        end else if (!div_trial[W]) begin
            acc_nxt = {div_trial[W-1:0], acc[W-2:0], 1'b1};
        end else begin
            acc_nxt = {div_rem[W-1:0], acc[W-2:0], 1'b0};
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc    <= '0;
            opnd   <= '0;
            cnt    <= '0;
            run    <= 1'b0;
            fin    <= 1'b0;
            mode_q <= MODE_MUL;
        end else if (go) begin
            acc    <= (mode == MODE_MUL) ? {{W{1'b0}}, b} : {{W{1'b0}}, a};
            opnd   <= (mode == MODE_MUL) ? a : b;
            cnt    <= CW'(W - 1);
            run    <= 1'b1;
            fin    <= 1'b0;
            mode_q <= mode;
        end else if (run) begin
            acc <= acc_nxt;
            cnt <= cnt - 1'b1;
            if (cnt == '0) begin
                run <= 1'b0;
                fin <= 1'b1;
            end
        end else begin
            fin <= 1'b0;
        end
    end

    assign lo = acc[W-1:0];
    assign hi = acc[2*W-1:W];

endmodule

// File: rtl/alu_seq16.sv
// Sequential 16-bit execute unit: captures operands on start, runs a single-cycle op
// or a W-cycle MUL/DIV, then presents result, flags and a one-cycle register write.
module alu_seq16
    import alu_seq_pkg::*;
#(
    parameter int W = ALU_W
) (
    input  logic      clk,
    input  logic      reset,
    alu_seq16_if.slave bus
);

    state_t        state;
    opcode_t       op_q;
    logic [W-1:0]  a_q;
    logic [W-1:0]  b_q;

    logic [W-1:0]  result_q;
    logic [W-1:0]  result_hi_q;
    flags_t        flags_q;
    logic          err_q;
    logic          busy_q;
    logic          done_q;
    logic          wr_en_q;

    logic          go;
    logic          finish;
    mode_t         eng_mode;
    logic [W-1:0]  eng_lo;
    logic [W-1:0]  eng_hi;
    logic          eng_fin;

    logic [W:0]    sum;
    logic [W:0]    diff;
    logic [W-1:0]  alu_res;
    logic [W-1:0]  alu_hi;
    logic          alu_c;
    logic          alu_v;
    logic          alu_err;
    flags_t        alu_flags;

    assign go       = (state == S_IDLE) && bus.start && is_iterative(bus.op, bus.b == '0);
    assign eng_mode = (bus.op == OP_DIV) ? MODE_DIV : MODE_MUL;
    assign finish   = (state == S_EXEC) || ((state == S_ITER) && eng_fin);

    seq_muldiv16 #(.W(W)) u_muldiv (
        .clk   (clk),
        .reset (reset),
        .go    (go),
        .mode  (eng_mode),
        .a     (bus.a),
        .b     (bus.b),
        .lo    (eng_lo),
        .hi    (eng_hi),
        .fin   (eng_fin)
    );

    assign sum  = {1'b0, a_q} + {1'b0, b_q};
    assign diff = {1'b0, a_q} - {1'b0, b_q};

    always_comb begin
        alu_res = '0;
        alu_hi  = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        alu_err = 1'b0;
        case (op_q)
            OP_ADD: begin
                alu_res = sum[W-1:0];
                alu_c   = sum[W];
                alu_v   = (a_q[W-1] == b_q[W-1]) && (sum[W-1] != a_q[W-1]);
            end
            OP_SUB: begin
                alu_res = diff[W-1:0];
                alu_c   = diff[W];
                alu_v   = (a_q[W-1] != b_q[W-1]) && (diff[W-1] != a_q[W-1]);
            end
            OP_AND: alu_res = a_q & b_q;
            OP_OR:  alu_res = a_q | b_q;
            OP_XOR: alu_res = a_q ^ b_q;
            OP_NOT: alu_res = ~a_q;
            OP_SHL: begin
                alu_res = {a_q[W-2:0], 1'b0};
                alu_c   = a_q[W-1];
            end
            OP_SHR: begin
                alu_res = {1'b0, a_q[W-1:1]};
                alu_c   = a_q[0];
            end
            OP_MUL: begin
                alu_res = eng_lo;
                alu_hi  = eng_hi;
                alu_c   = |eng_hi;
                alu_v   = |eng_hi;
            end
            OP_DIV: begin
                if (b_q == '0) begin
                    alu_res = '1;
                    alu_hi  = a_q;
                    alu_err = 1'b1;
                end else begin
                    alu_res = eng_lo;
                    alu_hi  = eng_hi;
                end
            end
            default: alu_err = 1'b1;
        endcase
        alu_flags.n = alu_res[W-1];
        alu_flags.z = (op_q == OP_MUL) ? ({alu_hi, alu_res} == '0) : (alu_res == '0);
        alu_flags.c = alu_c;
        alu_flags.v = alu_v;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            op_q        <= OP_ADD;
            a_q         <= '0;
            b_q         <= '0;
            result_q    <= '0;
            result_hi_q <= '0;
            flags_q     <= '0;
            err_q       <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            wr_en_q     <= 1'b0;
        end else begin
            done_q  <= 1'b0;
            wr_en_q <= 1'b0;
            // Outputs change only on completion and otherwise hold until the next one.
            if (finish) begin
                result_q    <= alu_res;
                result_hi_q <= alu_hi;
                flags_q     <= alu_flags;
                err_q       <= alu_err;
                done_q      <= 1'b1;
                wr_en_q     <= !alu_err;
            end
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        op_q  <= bus.op;
                        a_q   <= bus.a;
                        b_q   <= bus.b;
                        state <= go ? S_ITER : S_EXEC;
                    end
                end
                S_EXEC: state <= S_DONE;
                S_ITER: begin
                    if (eng_fin) begin
                        busy_q <= 1'b0;
                        state  <= S_DONE;
                    end else begin
                        busy_q <= 1'b1;
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.result    = result_q;
    assign bus.result_hi = result_hi_q;
    assign bus.flag_n    = flags_q.n;
    assign bus.flag_z    = flags_q.z;
    assign bus.flag_c    = flags_q.c;
    assign bus.flag_v    = flags_q.v;
    assign bus.err       = err_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.wr_en     = wr_en_q;

endmodule

// File: tb/tb_alu_seq16.sv
// Self-checking bench for alu_seq16: directed vector table plus hand-written
// sequences for ignored starts and reset in the middle of a multiply.
module tb_alu_seq16;
    import alu_seq_pkg::*;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;

    alu_seq16_if bus ();

    alu_seq16 dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] res;
        logic [15:0] hi;
        logic [3:0]  nzcv;
        logic        err;
        logic        wr;
        int          lat;
        int          busy;
    } vec_t;

    vec_t vecs[20];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [3:0] nzcv_now();
        return {bus.flag_n, bus.flag_z, bus.flag_c, bus.flag_v};
    endfunction

    // Issue one start, scramble the input buses, and wait (bounded) for done.
    task automatic run_op(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                          output int lat, output int busy_cnt);
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        @(negedge clk);
        bus.start = 1'b0;
        bus.op    = 4'hE;
        bus.a     = 16'hDEAD;
        bus.b     = 16'hBEEF;
        lat       = 0;
        busy_cnt  = 0;
        while (!bus.done && lat < 40) begin
            if (bus.busy) busy_cnt++;
            @(negedge clk);
            lat++;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int busy_cnt;
        int extra;
        logic [15:0] held;

        n_checks = 0;
        n_fail   = 0;

        //            op     a         b         res       hi        nzcv     err   wr    lat busy
        vecs[0]  = '{OP_ADD, 16'h7FFF, 16'h0001, 16'h8000, 16'h0000, 4'b1001, 1'b0, 1'b1, 1,  0};
        vecs[1]  = '{OP_SUB, 16'h0000, 16'h0001, 16'hFFFF, 16'h0000, 4'b1010, 1'b0, 1'b1, 1,  0};
        vecs[2]  = '{OP_AND, 16'hF0F0, 16'h3C3C, 16'h3030, 16'h0000, 4'b0000, 1'b0, 1'b1, 1,  0};
        vecs[3]  = '{OP_OR,  16'h0F00, 16'h00F0, 16'h0FF0, 16'h0000, 4'b0000, 1'b0, 1'b1, 1,  0};
        vecs[4]  = '{OP_XOR, 16'hAAAA, 16'hAAAA, 16'h0000, 16'h0000, 4'b0100, 1'b0, 1'b1, 1,  0};
        vecs[5]  = '{OP_NOT, 16'h00FF, 16'h1234, 16'hFF00, 16'h0000, 4'b1000, 1'b0, 1'b1, 1,  0};
        vecs[6]  = '{OP_SHL, 16'h8001, 16'h0000, 16'h0002, 16'h0000, 4'b0010, 1'b0, 1'b1, 1,  0};
        vecs[7]  = '{OP_SHR, 16'h0003, 16'h0000, 16'h0001, 16'h0000, 4'b0010, 1'b0, 1'b1, 1,  0};
        vecs[8]  = '{OP_ADD, 16'hFFFF, 16'h0001, 16'h0000, 16'h0000, 4'b0110, 1'b0, 1'b1, 1,  0};
        vecs[9]  = '{OP_SUB, 16'h8000, 16'h0001, 16'h7FFF, 16'h0000, 4'b0001, 1'b0, 1'b1, 1,  0};
        vecs[10] = '{OP_MUL, 16'h1234, 16'h0100, 16'h3400, 16'h0012, 4'b0011, 1'b0, 1'b1, 17, 16};
        vecs[11] = '{OP_MUL, 16'h00FF, 16'h0101, 16'hFFFF, 16'h0000, 4'b1000, 1'b0, 1'b1, 17, 16};
        vecs[12] = '{OP_MUL, 16'hFFFF, 16'hFFFF, 16'h0001, 16'hFFFE, 4'b0011, 1'b0, 1'b1, 17, 16};
        vecs[13] = '{OP_MUL, 16'h0000, 16'h1234, 16'h0000, 16'h0000, 4'b0100, 1'b0, 1'b1, 17, 16};
        vecs[14] = '{OP_DIV, 16'h0064, 16'h0007, 16'h000E, 16'h0002, 4'b0000, 1'b0, 1'b1, 17, 16};
        vecs[15] = '{OP_DIV, 16'h0064, 16'h0000, 16'hFFFF, 16'h0064, 4'b1000, 1'b1, 1'b0, 1,  0};
        vecs[16] = '{OP_DIV, 16'hFFFF, 16'h0001, 16'hFFFF, 16'h0000, 4'b1000, 1'b0, 1'b1, 17, 16};
        vecs[17] = '{OP_DIV, 16'h0003, 16'h0007, 16'h0000, 16'h0003, 4'b0100, 1'b0, 1'b1, 17, 16};
        vecs[18] = '{4'hB,   16'h1234, 16'h5678, 16'h0000, 16'h0000, 4'b0100, 1'b1, 1'b0, 1,  0};
        vecs[19] = '{4'hF,   16'hFFFF, 16'hFFFF, 16'h0000, 16'h0000, 4'b0100, 1'b1, 1'b0, 1,  0};

        reset     = 1'b1;
        bus.start = 1'b0;
        bus.op    = OP_ADD;
        bus.a     = '0;
        bus.b     = '0;
        repeat (2) @(negedge clk);
        check("reset result/hi", {bus.result, bus.result_hi}, 32'h0);
        check("reset flags/err/busy/done/wr_en",
              {nzcv_now(), bus.err, bus.busy, bus.done, bus.wr_en}, 32'h0);
        reset = 1'b0;

        for (int i = 0; i < 20; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, lat, busy_cnt);
            check($sformatf("v%0d done seen", i), bus.done, 1);
            check($sformatf("v%0d latency", i), lat, vecs[i].lat);
            check($sformatf("v%0d busy cycles", i), busy_cnt, vecs[i].busy);
            check($sformatf("v%0d result", i), bus.result, vecs[i].res);
            check($sformatf("v%0d result_hi", i), bus.result_hi, vecs[i].hi);
            check($sformatf("v%0d nzcv", i), nzcv_now(), vecs[i].nzcv);
            check($sformatf("v%0d err", i), bus.err, vecs[i].err);
            check($sformatf("v%0d wr_en", i), bus.wr_en, vecs[i].wr);
            @(negedge clk);
            check($sformatf("v%0d done/wr_en pulse end", i), {bus.done, bus.wr_en}, 0);
            check($sformatf("v%0d result hold", i), bus.result, vecs[i].res);
        end

        // Start pulsed mid-MUL and again during the done cycle: both ignored.
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = OP_MUL;
        bus.a     = 16'h0003;
        bus.b     = 16'h0005;
        @(negedge clk);
        lat = 0;
        while (!bus.done && lat < 40) begin
            if (lat == 5) begin
                bus.start = 1'b1;
                bus.op    = OP_ADD;
                bus.a     = 16'h0001;
                bus.b     = 16'h0001;
            end else begin
                bus.start = 1'b0;
            end
            @(negedge clk);
            lat++;
        end
        check("busy-start mul latency", lat, 17);
        check("busy-start mul result", {bus.result_hi, bus.result}, 32'h0000_000F);
        bus.start = 1'b1;
        bus.op    = OP_ADD;
        bus.a     = 16'h0002;
        bus.b     = 16'h0002;
        @(negedge clk);
        bus.start = 1'b0;
        extra = 0;
        repeat (20) begin
            if (bus.done || bus.busy) extra++;
            @(negedge clk);
        end
        check("ignored starts: no extra activity", extra, 0);
        check("ignored starts: result held", bus.result, 16'h000F);

        // Reset at MUL iteration 8 clears everything immediately.
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = OP_MUL;
        bus.a     = 16'hFFFF;
        bus.b     = 16'hFFFF;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (8) @(negedge clk);
        check("mid-mul busy before reset", bus.busy, 1);
        reset = 1'b1;
        #1;
        check("mid-mul reset result/hi", {bus.result, bus.result_hi}, 32'h0);
        check("mid-mul reset flags/err/busy/done/wr_en",
              {nzcv_now(), bus.err, bus.busy, bus.done, bus.wr_en}, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        extra = 0;
        repeat (20) begin
            if (bus.done || bus.busy) extra++;
            @(negedge clk);
        end
        check("after reset: aborted mul stays dead", extra, 0);
        held = 16'h0003;
        run_op(OP_ADD, held, 16'h0004, lat, busy_cnt);
        check("post-reset add latency", lat, 1);
        check("post-reset add result", bus.result, 16'h0007);
        check("post-reset add wr_en", bus.wr_en, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
